// File: rtl/ser_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ser_bus_bridge
// Description : Byte-stream to memory-bus bridge. This block takes command
//               frames from a serial receiver's byte strobe. It issues one
//               32-bit word read or write as an initiator on the native
//               valid/ready memory bus. It returns the response bytes to a
//               serial transmitter.
//
//               Frames (multi-byte fields MSB first):
//                 'R' (0x52) + 4 address bytes
//                 'W' (0x57) + 4 address bytes + 4 data bytes
//               Responses:
//                 read ok  -> 4 read-data bytes, MSB first
//                 write ok -> 'K' (0x4B)
//                 timeout  -> 'E' (0x45) only
//
// Parameters  : TIMEOUT    cycles mem_valid may wait for mem_ready before the
//                          transaction is abandoned (1..65535)
// Ports       : clk_24     system clock, rising edge
//               reset      synchronous active-high reset
//               rx_valid   one-cycle strobe, byte present on rx_data
//               rx_data    received byte
//               tx_valid   byte to transmit present on tx_data
//               tx_data    byte to transmit
//               tx_ready   transmitter accepts tx_data this cycle
//               mem_valid  bus request
//               mem_instr  always 0 (data access)
//               mem_ready  bus completion strobe
//               mem_addr   word address, bits [1:0] always 0
//               mem_wdata  write data
//               mem_wstrb  4'hF for writes, 4'h0 for reads
//               mem_rdata  read data, valid while mem_ready=1
//               busy       high whenever the FSM is not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module ser_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_24,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [7:0]  c_CMD_READ  = 8'h52;
    localparam logic [7:0]  c_CMD_WRITE = 8'h57;
    localparam logic [7:0]  c_RESP_OK   = 8'h4B;
    localparam logic [7:0]  c_RESP_ERR  = 8'h45;
    localparam logic [15:0] c_TIMEOUT   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_is_write;
    logic [1:0]  r_bcnt;      // frame byte index, then remaining read bytes
    logic        r_err;
    logic [15:0] r_tcnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;     // pre-shifted: [31:24] is always the next byte
    logic        r_mem_valid;
    logic [3:0]  r_wstrb;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;

    logic w_is_cmd;
    logic w_last_field_byte;
    logic w_tx_accept;
    logic w_resp_last;

    assign w_is_cmd          = (rx_data == c_CMD_READ) || (rx_data == c_CMD_WRITE);
    assign w_last_field_byte = (r_bcnt == 2'd3);
    assign w_tx_accept       = r_tx_valid && tx_ready;
    // A write ack and an error reply are a single byte. A read reply ends
    // when no data bytes remain.
    assign w_resp_last       = r_err || r_is_write || (r_bcnt == 2'd0);

    always_ff @(posedge clk_24) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_is_write  <= 1'b0;
            r_bcnt      <= 2'd0;
            r_err       <= 1'b0;
            r_tcnt      <= 16'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_mem_valid <= 1'b0;
            r_wstrb     <= 4'h0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Anything other than a command byte is discarded here.
                    if (rx_valid && w_is_cmd) begin
                        r_is_write <= (rx_data == c_CMD_WRITE);
                        r_bcnt     <= 2'd0;
                        r_err      <= 1'b0;
                        r_state    <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (rx_valid) begin
                        r_addr <= {r_addr[23:0], rx_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (w_last_field_byte) begin
                            if (r_is_write) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state     <= ST_BUS;
                                r_mem_valid <= 1'b1;
                                r_wstrb     <= 4'h0;
                                r_tcnt      <= 16'd0;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (w_last_field_byte) begin
                            r_state     <= ST_BUS;
                            r_mem_valid <= 1'b1;
                            r_wstrb     <= 4'hF;
                            r_tcnt      <= 16'd0;
                        end
                    end
                end

                ST_BUS: begin
                    // mem_ready takes priority over an expiring timeout.
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_wstrb     <= 4'h0;
                        r_tx_valid  <= 1'b1;
                        r_state     <= ST_RESP;
                        if (r_is_write) begin
                            r_tx_data <= c_RESP_OK;
                        end else begin
                            r_tx_data <= mem_rdata[31:24];
                            r_rdata   <= {mem_rdata[23:0], 8'd0};
                            r_bcnt    <= 2'd3;
                        end
                    end else if (r_tcnt == c_TIMEOUT) begin
                        r_mem_valid <= 1'b0;
                        r_wstrb     <= 4'h0;
                        r_err       <= 1'b1;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= c_RESP_ERR;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end

                ST_RESP: begin
                    if (w_tx_accept) begin
                        if (w_resp_last) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tx_data <= r_rdata[31:24];
                            r_rdata   <= {r_rdata[23:0], 8'd0};
                            r_bcnt    <= r_bcnt - 2'd1;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                    r_tx_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign mem_valid = r_mem_valid;
    assign mem_instr = 1'b0;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ser_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_bus_bridge
// Description : Vector-table bench for ser_bus_bridge (TIMEOUT=8). Each record
//               holds one frame, a bus responder delay, a tx_ready pattern and
//               hand-computed expected bus fields and reply bytes. The records
//               are followed by hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_bus_bridge;

    localparam int         c_TIMEOUT    = 8;
    localparam int         c_MON_CYCLES = 40;
    localparam logic [7:0] c_CMD_R      = 8'h52;
    localparam logic [7:0] c_CMD_W      = 8'h57;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;         // ready on mem_valid cycle d+1; -1 = never
        logic [7:0]  pat;       // tx_ready per tx_valid cycle, bit0 first
        int          plen;      // pattern length, then tx_ready=1
        bit          pre_junk;  // send 0x00,0xFF and a stray mem_ready first
        bit          junk;      // strobe 'R' during BUS/RESP
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        int          e_vc;      // mem_valid high cycles
        int          e_n;       // reply byte count
        logic [31:0] e_bytes;   // reply bytes, first in [31:24]
    } vec_t;

    logic        clk_24    = 1'b0;
    logic        reset     = 1'b1;
    logic        rx_valid  = 1'b0;
    logic [7:0]  rx_data   = 8'd0;
    logic        tx_ready  = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vec_t vecs [7];
    vec_t v_rst;
    vec_t v_bus;

    ser_bus_bridge #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk_24    (clk_24),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk_24 = ~clk_24;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"},   32'({tx_valid, mem_valid, busy, mem_instr}), 32'd0);
        check({tag, "_txd"},   32'(tx_data),   32'd0);
        check({tag, "_addr"},  mem_addr,       32'd0);
        check({tag, "_wdata"}, mem_wdata,      32'd0);
        check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
    endtask

    // Entered and left at a falling edge; the byte is taken at the rising edge between.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_24);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input string tag);
        send_byte(v.wr ? c_CMD_W : c_CMD_R);
        check({tag, "_busy_after_cmd"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(v.addr[31-8*i -: 8]);
        if (v.wr) begin
            for (int i = 0; i < 4; i++) send_byte(v.wdata[31-8*i -: 8]);
        end
    endtask

    // Starts in the cycle after the final frame byte was accepted.
    task automatic run_txn(input vec_t v, input string tag);
        int          vc, rises, first_v, first_t, nb, pi, unstable;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        logic        pmv, ptv, ptr, tr;
        logic [7:0]  ptd;
        logic [7:0]  got [4];
        vc = 0; rises = 0; first_v = -1; first_t = -1; nb = 0; pi = 0; unstable = 0;
        s_addr = 32'd0; s_wdata = 32'd0; s_wstrb = 4'd0;
        pmv = 1'b0; ptv = 1'b0; ptr = 1'b0; ptd = 8'd0; tr = 1'b0;
        for (int k = 0; k < 4; k++) got[k] = 8'd0;
        for (int c = 0; c < c_MON_CYCLES; c++) begin
            if (mem_valid) begin
                if (!pmv) rises++;
                if (first_v < 0) begin
                    first_v = c;
                    s_addr  = mem_addr;
                    s_wdata = mem_wdata;
                    s_wstrb = mem_wstrb;
                end
                vc++;
            end
            mem_ready = mem_valid && (v.d >= 0) && (vc == v.d + 1);
            mem_rdata = mem_ready ? v.rdata : 32'hBAD0_BAD0;
            if (tx_valid) begin
                if (first_t < 0) first_t = c;
                if (ptv && !ptr && (tx_data !== ptd)) unstable++;
                tr = (pi < v.plen) ? v.pat[pi] : 1'b1;
                pi++;
                if (tr) begin
                    if (nb < 4) got[nb] = tx_data;
                    nb++;
                end
            end else begin
                tr = 1'b0;
            end
            tx_ready = tr;
            rx_valid = v.junk && (mem_valid || tx_valid);
            rx_data  = c_CMD_R;
            pmv = mem_valid;
            ptv = tx_valid;
            ptr = tr;
            ptd = tx_data;
            @(negedge clk_24);
        end
        mem_ready = 1'b0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        check({tag, "_mv_latency"}, 32'(first_v), 32'd0);
        check({tag, "_addr"},       s_addr, v.e_addr);
        check({tag, "_wstrb"},      32'(s_wstrb), 32'(v.e_wstrb));
        if (v.wr) check({tag, "_wdata"}, s_wdata, v.wdata);
        check({tag, "_mv_cycles"},  32'(vc), 32'(v.e_vc));
        check({tag, "_mv_rises"},   32'(rises), 32'd1);
        check({tag, "_tx_latency"}, 32'(first_t), 32'(v.e_vc));
        check({tag, "_tx_stable"},  32'(unstable), 32'd0);
        check({tag, "_tx_count"},   32'(nb), 32'(v.e_n));
        for (int k = 0; k < 4; k++) begin
            if (k < v.e_n) check($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(v.e_bytes[31-8*k -: 8]));
        end
        check({tag, "_idle_end"},   32'({busy, tx_valid, mem_valid, mem_instr}), 32'd0);
    endtask

    initial begin
        //           wr  addr          wdata         rdata         d   pat    plen pj jk e_addr        e_wstrb e_vc e_n e_bytes
        vecs[0] = '{1'b0, 32'h1000_0008, 32'h0,        32'hDEAD_BEEF,  1, 8'hFF, 0, 1'b0, 1'b0, 32'h1000_0008, 4'h0, 2, 4, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h2000_0003, 32'h1234_5678, 32'h0,         1, 8'hFF, 0, 1'b0, 1'b0, 32'h2000_0000, 4'hF, 2, 1, 32'h4B00_0000};
        vecs[2] = '{1'b0, 32'h6000_0000, 32'h0,        32'h0,         -1, 8'hFF, 0, 1'b0, 1'b0, 32'h6000_0000, 4'h0, 9, 1, 32'h4500_0000};
        vecs[3] = '{1'b0, 32'h6000_0000, 32'h0,        32'hA5C3_0F81,  8, 8'hFF, 0, 1'b0, 1'b0, 32'h6000_0000, 4'h0, 9, 4, 32'hA5C3_0F81};
        vecs[4] = '{1'b1, 32'h0000_0ABE, 32'hCAFE_F00D, 32'h0,        -1, 8'hFF, 0, 1'b0, 1'b0, 32'h0000_0ABC, 4'hF, 9, 1, 32'h4500_0000};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0102_0304,  3, 8'h74, 7, 1'b1, 1'b1, 32'hFFFF_FFFC, 4'h0, 4, 4, 32'h0102_0304};
        vecs[6] = '{1'b1, 32'h0000_1000, 32'h8000_0001, 32'h0,         2, 8'hFF, 0, 1'b0, 1'b1, 32'h0000_1000, 4'hF, 3, 1, 32'h4B00_0000};
        v_rst   = '{1'b1, 32'h3000_0010, 32'h0000_0055, 32'h0,         1, 8'hFF, 0, 1'b0, 1'b0, 32'h3000_0010, 4'hF, 2, 1, 32'h4B00_0000};
        v_bus   = '{1'b0, 32'h4000_0000, 32'h0,        32'h0,         -1, 8'hFF, 0, 1'b0, 1'b0, 32'h4000_0000, 4'h0, 9, 1, 32'h4500_0000};

        repeat (3) @(negedge clk_24);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk_24);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pre_junk) begin
                send_byte(8'h00);
                send_byte(8'hFF);
                mem_ready = 1'b1;
                @(negedge clk_24);
                mem_ready = 1'b0;
                check($sformatf("v%0d_junk_idle", i), 32'({busy, mem_valid, tx_valid}), 32'd0);
            end
            send_frame(vecs[i], $sformatf("v%0d", i));
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in DATA after two data bytes, then a fresh write frame.
        send_byte(c_CMD_W);
        for (int i = 0; i < 4; i++) send_byte(8'hAA);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        @(negedge clk_24);
        reset = 1'b0;
        check_zero("rst_data");
        send_frame(v_rst, "rst_w");
        run_txn(v_rst, "rst_w");

        // Reset while a read waits on the bus: the request drops and no reply follows.
        send_frame(v_bus, "rst_bus");
        check("rst_bus_mv_up", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk_24);
        reset = 1'b0;
        check_zero("rst_bus");
        begin
            int act_cnt;
            act_cnt = 0;
            tx_ready = 1'b1;
            for (int c = 0; c < 15; c++) begin
                if (tx_valid || mem_valid) act_cnt++;
                @(negedge clk_24);
            end
            tx_ready = 1'b0;
            check("rst_bus_silent", 32'(act_cnt), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ser_bus_bridge.md
# ser_bus_bridge

Byte-stream-to-memory-bus bridge: the initiator end of the SoC's native valid/ready memory bus. It takes command bytes from a serial receiver's byte strobe, issues single 32-bit word reads or writes on the same bus protocol the CPU core drives, and returns the result bytes to a serial transmitter. It sits between the ACIA byte interface and a bus arbiter port, giving a host PC debug and load access to ROM, RAM and peripherals.

## Interface
- `TIMEOUT`, default 255: maximum cycles `mem_valid` is held without `mem_ready` before the transaction is abandoned; legal range 1..65535.

- `clk_24`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; a received byte is present on `rx_data`.
- `rx_data`  in  8  received byte.
- `tx_valid`  out  1  a byte to transmit is present on `tx_data`.
- `tx_data`  out  8  byte to transmit.
- `tx_ready`  in  1  the transmitter accepts `tx_data` this cycle.
- `mem_valid`  out  1  bus request.
- `mem_instr`  out  1  constant 0.
- `mem_ready`  in  1  bus completion, one cycle.
- `mem_addr`  out  32  word address; bits [1:0] are always 0.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'hF for writes, 4'h0 for reads.
- `mem_rdata`  in  32  read data; valid only in the cycle `mem_ready`=1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Command frames (all multi-byte fields are sent MSB first):
  - Read: 0x52 ('R'), then 4 address bytes.
  - Write: 0x57 ('W'), then 4 address bytes, then 4 data bytes.
- Any other byte received in IDLE is discarded, and the FSM stays in IDLE.
- State machine:
  - IDLE -> ADDR when the byte is 'R' or 'W'. The op flag is latched and the 2-bit byte counter is cleared.
  - ADDR: each strobed byte shifts into an address register (`addr <= {addr[23:0], byte}`). On the 4th byte, go to BUS for a read or to DATA for a write.
  - DATA: 4 strobed bytes shift into `wdata` the same way. On the 4th byte, go to BUS.
  - BUS: `mem_valid`=1 with a stable address, data and strobe. If `mem_ready`=1, latch `mem_rdata` (for a read) and go to RESP. If instead the timeout counter reaches `TIMEOUT`, set the error flag and go to RESP.
  - RESP: present the response bytes, then return to IDLE.
- Responses:
  - Successful read: 4 bytes of read data, MSB first.
  - Successful write: 0x4B ('K').
  - Timeout on either op: a single 0x45 ('E'), with no data bytes.
- `rx_valid` has no backpressure. Bytes strobed while in BUS or RESP are dropped, and no partial frame is started.
- The timeout counter is 16 bits wide. It clears on entry to BUS and increments on every BUS cycle in which `mem_ready`=0.
- If `mem_ready`=1 in the same cycle the counter equals `TIMEOUT`, `mem_ready` wins: the transaction succeeds.
- A `mem_ready` arriving while `mem_valid`=0 is ignored.

## Timing
- Reset values:
  - `tx_valid`, `mem_valid`, `busy` = 0.
  - `tx_data`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0.
  - FSM in IDLE, byte counter and error flag cleared.
- Reset mid-frame or mid-transaction aborts immediately: `mem_valid` drops in the cycle after reset is sampled, and no response is sent.
- Byte accepted in cycle N (final address byte for 'R', final data byte for 'W') -> `mem_valid`=1 from cycle N+1.
- `mem_ready` sampled high in cycle M -> `mem_valid`=0 and `tx_valid`=1 with the first response byte, both in cycle M+1.
- The earliest possible `mem_ready` is the cycle after `mem_valid` rises; the SoC's registered ready achieves exactly this.
- Timeout: with no ready, `mem_valid` is high for `TIMEOUT`+1 cycles, then `tx_valid`=1 with 0x45 in the following cycle.
- TX handshake:
  - `tx_data` stays stable while `tx_valid`=1 and `tx_ready`=0.
  - Acceptance is `tx_valid & tx_ready`. The next byte is presented in the following cycle, so a 4-byte read response takes at least 4 cycles.
  - `tx_valid` drops the cycle after the last byte is accepted; the FSM is in IDLE that same cycle.
- `busy` rises in the cycle after a valid command byte and falls in the same cycle the FSM returns to IDLE.

## Test plan
- Read:
  - Stimulus: 'R', 10 00 00 08, with the responder asserting `mem_ready` 1 cycle after `mem_valid` and `mem_rdata`=0xDEADBEEF.
  - Required: `mem_addr`=0x10000008, `mem_wstrb`=0, `mem_valid` high for exactly 2 cycles, TX bytes DE AD BE EF.
- Write:
  - Stimulus: 'W', 20 00 00 03, 12 34 56 78.
  - Required: `mem_addr`=0x20000000 (bits [1:0] forced to 0), `mem_wdata`=0x12345678, `mem_wstrb`=4'hF, TX byte 0x4B.
- Timeout:
  - Stimulus: `TIMEOUT`=8, 'R' to 0x60000000, no `mem_ready`.
  - Required: `mem_valid` high for 9 cycles, then TX byte 0x45 only.
  - Repeat with `mem_ready` on the 9th cycle: the read succeeds with 4 data bytes.
- Junk and dropped bytes:
  - Stimulus: bytes 0x00, 0xFF in IDLE, then a valid 'R' frame.
  - Required: no bus activity from the junk; the 'R' frame completes normally.
  - Strobing extra bytes during BUS/RESP must not start a new frame.
- TX backpressure:
  - Stimulus: `tx_ready` toggling 0,0,1,0,1,1,1 during a read response.
  - Required: each byte is held stable until accepted; byte order is intact.
- Reset:
  - Stimulus: assert `reset` for 1 cycle while in DATA after 2 data bytes, then send a full 'W' frame.
  - Required: all outputs are 0 after reset, and the new write carries only the new frame's address and data.
